// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared state, mode and instruction constants for the fetch sequencer
package fetch_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALT} seq_state_t;
    localparam logic [1:0] MODE_REG = 2'b00;
    localparam logic [1:0] MODE_TGT = 2'b01;
    localparam logic [1:0] MODE_IMM = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;
    localparam logic [8:0] NOP_INSTR = 9'h000;
endpackage

// File: rtl/program_counter.sv
// program_counter: loadable, incrementing PC with async reset to the start address
module program_counter #(
    parameter int PC_W = 10,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Init,
    input  logic            Load,
    input  logic            Inc,
    input  logic [PC_W-1:0] LoadVal,
    output logic [PC_W-1:0] Count
);
    logic [PC_W-1:0] count_q, count_d;

    // Init restarts the program, Load takes a branch, Inc steps sequentially
    always_comb begin
        count_d = Init ? START_ADDR : Load ? LoadVal : Inc ? count_q + PC_W'(1) : count_q;
    end

    // PC register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) count_q <= START_ADDR;
        else       count_q <= count_d;
    end

    assign Count = count_q;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC, decode mode and previous-instruction holder with Start/Done run control
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int          PC_W       = 10,
    parameter int unsigned START_ADDR = 0,
    parameter int          CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    output logic [PC_W-1:0]  InstrAddr,
    input  logic [8:0]       InstrData,
    output logic [8:0]       Instruction,
    output logic [8:0]       PrevInstruction,
    output logic [1:0]       CurrState,
    input  logic [1:0]       NextState,
    input  logic [8:0]       PrevInstrIn,
    input  logic             BranchEn,
    input  logic [8:0]       BranchTarget,
    input  logic             AckIn,
    output logic             Done,
    output logic             Busy,
    output logic [CNT_W-1:0] CycleCount
);
    seq_state_t       state_q, state_d;
    logic             start_q;
    logic [1:0]       mode_q, mode_d;
    logic [8:0]       prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run, start_rise, init, advance, load, inc;
    logic [PC_W-1:0]  target;

    assign run        = state_q == RUN;
    assign start_rise = Start & ~start_q;
    assign init       = ~run & start_rise;
    assign advance    = run & ~AckIn;
    assign load       = advance & BranchEn;
    assign inc        = advance & ~BranchEn;
    assign target     = PC_W'(BranchTarget);

    // Next run state, mode, previous instruction and saturating cycle count
    always_comb begin
        state_d = init ? RUN : (run && AckIn) ? HALT : state_q;
        mode_d  = init ? MODE_REG : advance ? ((NextState == MODE_RSV) ? MODE_REG : NextState) : mode_q;
        prev_d  = init ? NOP_INSTR : advance ? PrevInstrIn : prev_q;
        cnt_d   = init ? '0 : (run && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Sequencer registers, cleared immediately by Reset
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            mode_q  <= MODE_REG;
            prev_q  <= NOP_INSTR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= Start;
            mode_q  <= mode_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    program_counter #(.PC_W(PC_W), .START_ADDR(PC_W'(START_ADDR))) u_pc (
        .Clk    (Clk),
        .Reset  (Reset),
        .Init   (init),
        .Load   (load),
        .Inc    (inc),
        .LoadVal(target),
        .Count  (InstrAddr)
    );

    assign Instruction     = run ? InstrData : NOP_INSTR;
    assign PrevInstruction = prev_q;
    assign CurrState       = mode_q;
    assign Done            = state_q == HALT;
    assign Busy            = run;
    assign CycleCount      = cnt_q;
endmodule
